// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and default sizing for spi_shift_engine
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
  localparam int CLK_DIV_DEF = 4;
  localparam int DATA_W_DEF = 8;
  function automatic int bit_cnt_w(input int w);
    return $clog2(2 * w) + 1;
  endfunction
endpackage

// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: register-block handshake plus SPI pins; slave is the engine's view
interface spi_shift_engine_if import spi_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic start;
  logic busy;
  logic new_data;
  logic miso;
  logic mosi;
  logic sck;
  logic ss;
  modport master(output data_in, start, miso, input data_out, busy, new_data, mosi, sck, ss);
  modport slave(input data_in, start, miso, output data_out, busy, new_data, mosi, sck, ss);
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: one-cycle tick every DIV clocks while enabled, counter cleared when disabled
module spi_clk_div import spi_pkg::*; #(parameter int DIV = CLK_DIV_DEF) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV + 1);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 byte-serial SPI master; rst is async active-low.
// Define SPI_LSB_FIRST_EN to send/receive LSB first (default MSB first).
module spi_shift_engine import spi_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic rst,
  spi_shift_engine_if.slave bus
);
  localparam int BW = bit_cnt_w(DATA_W);
  state_t state, state_nx;
  logic start_q, tick, accept, rise, last_fall, sck, mosi, new_data;
  logic [BW-1:0] hcnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_nx, rx_nx, data_out;
`ifdef SPI_LSB_FIRST_EN
  localparam int FIRST = 0;
  assign tx_nx = tx_sr >> 1;
  assign rx_nx = {bus.miso, rx_sr[DATA_W-1:1]};
`else
  localparam int FIRST = DATA_W - 1;
  assign tx_nx = tx_sr << 1;
  assign rx_nx = {rx_sr[DATA_W-2:0], bus.miso};
`endif
  spi_clk_div #(.DIV(CLK_DIV)) u_div (.clk, .rst, .en(state != IDLE), .tick);
  assign accept = state == IDLE && bus.start && !start_q;
  assign rise = tick && state == XFER && sck == CPOL;
  assign last_fall = hcnt == BW'(2 * DATA_W - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? SETUP : IDLE)
             : !tick ? state
             : state == SETUP ? XFER
             : state == XFER ? (last_fall ? HOLD : XFER)
             : IDLE;
  always_comb begin
    bus.ss = state == IDLE;
    bus.busy = state != IDLE;
    bus.sck = sck;
    bus.mosi = mosi;
    bus.data_out = data_out;
    bus.new_data = new_data;
  end
  // hcnt counts sck half-periods; even ticks are rises, the last odd tick ends the byte
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      start_q <= 1'b0;
      sck <= CPOL;
      mosi <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
      hcnt <= '0;
      data_out <= '0;
      new_data <= 1'b0;
    end else begin
      start_q <= bus.start;
      if (accept) begin
        tx_sr <= bus.data_in;
        mosi <= bus.data_in[FIRST];
        hcnt <= '0;
        sck <= CPOL;
        new_data <= 1'b0;
      end else if (tick && state == XFER) begin
        sck <= ~sck;
        hcnt <= hcnt + 1'b1;
        if (rise) rx_sr <= rx_nx;
        else if (!last_fall) begin
          tx_sr <= tx_nx;
          mosi <= tx_nx[FIRST];
        end
      end else if (tick && state == HOLD) begin
        data_out <= rx_sr;
        new_data <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: two engines (CLK_DIV 4 and 1) against a cycle-count timeline model
module tb_spi_shift_engine;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [D-1:0] din[2];
  logic st[2];
  logic [1:0] mode[2];
  logic [D-1:0] dout[2];
  logic bsy[2], nd[2], mo[2], sk[2], ssn[2];
  int n_chk = 0;
  int n_pass = 0;
  int rises[2] = '{0, 0};
  logic [D-1:0] col[2] = '{8'h00, 8'h00};
  spi_shift_engine_if #(.DATA_W(D)) b0();
  spi_shift_engine_if #(.DATA_W(D)) b1();
  spi_shift_engine #(.CLK_DIV(4), .DATA_W(D)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  spi_shift_engine #(.CLK_DIV(1), .DATA_W(D)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  assign b0.data_in = din[0];
  assign b0.start = st[0];
  assign b0.miso = mode[0] == 2'd2 ? b0.mosi : mode[0][0];
  assign b1.data_in = din[1];
  assign b1.start = st[1];
  assign b1.miso = mode[1] == 2'd2 ? b1.mosi : mode[1][0];
  assign dout[0] = b0.data_out;
  assign bsy[0] = b0.busy;
  assign nd[0] = b0.new_data;
  assign mo[0] = b0.mosi;
  assign sk[0] = b0.sck;
  assign ssn[0] = b0.ss;
  assign dout[1] = b1.data_out;
  assign bsy[1] = b1.busy;
  assign nd[1] = b1.new_data;
  assign mo[1] = b1.mosi;
  assign sk[1] = b1.sck;
  assign ssn[1] = b1.ss;
  always @(posedge b0.sck) begin
    rises[0] <= rises[0] + 1;
    col[0] <= {col[0][D-2:0], mo[0]};
  end
  always @(posedge b1.sck) begin
    rises[1] <= rises[1] + 1;
    col[1] <= {col[1][D-2:0], mo[1]};
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
  endtask
  // model: a transfer is just a cycle count since acceptance; every pin follows from it
  logic mb[2], msq[2], mrun[2], mnd[2];
  int mc[2];
  logic [D-1:0] mdata[2], mrx[2], mdout[2];
  function automatic int divof(input int i);
    return i == 0 ? 4 : 1;
  endfunction
  function automatic int tot(input int i);
    return (2 * D + 2) * divof(i);
  endfunction
  function automatic logic e_sck(input int i);
    int k;
    k = mc[i] / divof(i);
    return mb[i] && k % 2 == 0 && k >= 2 && k <= 2 * D;
  endfunction
  function automatic logic e_mosi(input int i);
    int k, j;
    k = mc[i] / divof(i);
    j = k < 3 ? 0 : (k - 1) / 2;
    if (j > D - 1) j = D - 1;
    if (!mrun[i]) return 1'b0;
`ifdef SPI_LSB_FIRST_EN
    return mdata[i][j];
`else
    return mdata[i][D-1-j];
`endif
  endfunction
  always @(posedge clk or negedge rst)
    for (int i = 0; i < 2; i++)
      if (!rst) begin
        mb[i] <= 1'b0;
        msq[i] <= 1'b0;
        mrun[i] <= 1'b0;
        mnd[i] <= 1'b0;
        mc[i] <= 0;
        mdata[i] <= '0;
        mrx[i] <= '0;
        mdout[i] <= '0;
      end else begin
        msq[i] <= st[i];
        if (!mb[i] && st[i] && !msq[i]) begin
          mb[i] <= 1'b1;
          mrun[i] <= 1'b1;
          mc[i] <= 0;
          mnd[i] <= 1'b0;
          mdata[i] <= din[i];
          mrx[i] <= mode[i] == 2'd2 ? din[i] : {D{mode[i][0]}};
        end else if (mb[i]) begin
          mc[i] <= mc[i] + 1;
          if (mc[i] + 1 == tot(i)) begin
            mb[i] <= 1'b0;
            mnd[i] <= 1'b1;
            mdout[i] <= mrx[i];
          end
        end
      end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), int'(bsy[i]), int'(mb[i]));
      chk($sformatf("ss%0d", i), int'(ssn[i]), int'(!mb[i]));
      chk($sformatf("sck%0d", i), int'(sk[i]), int'(e_sck(i)));
      chk($sformatf("mosi%0d", i), int'(mo[i]), int'(e_mosi(i)));
      chk($sformatf("new_data%0d", i), int'(nd[i]), int'(mnd[i]));
      chk($sformatf("data_out%0d", i), int'(dout[i]), int'(mdout[i]));
    end
  task automatic xfer(input int i, input logic [D-1:0] d, input logic [1:0] md, input int hold,
                      input int poke, input int exp_lat, input logic [D-1:0] exp_dout,
                      input logic [D-1:0] exp_col);
    int n, r0, lat;
    n = 0;
    lat = -1;
    @(negedge clk);
    din[i] = d;
    mode[i] = md;
    r0 = rises[i];
    st[i] = 1'b1;
    while (n < 600 && (lat < 0 || n < hold)) begin
      @(negedge clk);
      n++;
      st[i] = (n < hold) || (n == poke);
      if (lat < 0 && !bsy[i]) lat = n - 1;
    end
    st[i] = 1'b0;
    chk("latency", lat, exp_lat);
    chk("sck_rises", rises[i] - r0, 8);
    chk("lit_data_out", int'(dout[i]), int'(exp_dout));
    chk("lit_new_data", int'(nd[i]), 1);
    chk("lit_ss_idle", int'(ssn[i]), 1);
    chk("mosi_bits", int'(col[i]), int'(exp_col));
  endtask
  initial begin
    logic [D-1:0] col01;
    int n;
`ifdef SPI_LSB_FIRST_EN
    col01 = 8'h80;
`else
    col01 = 8'h01;
`endif
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      din[i] = '0;
      mode[i] = 2'd2;
    end
    repeat (3) @(negedge clk);
    chk("rst_ss", int'(ssn[0]), 1);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_data_out", int'(dout[1]), 0);
    rst = 1'b1;
    xfer(0, 8'hA5, 2'd2, 1, -1, 72, 8'hA5, 8'hA5);
    xfer(0, 8'h3C, 2'd1, 1, -1, 72, 8'hFF, 8'h3C);
    xfer(0, 8'h3C, 2'd0, 1, -1, 72, 8'h00, 8'h3C);
    xfer(0, 8'h5A, 2'd2, 100, -1, 72, 8'h5A, 8'h5A);
    xfer(0, 8'hC3, 2'd2, 1, 20, 72, 8'hC3, 8'hC3);
    xfer(0, 8'h99, 2'd2, 1, 72, 72, 8'h99, 8'h99);
    repeat (3) @(negedge clk);
    chk("no_accept_at_fall", int'(bsy[0]), 0);
    din[0] = 8'hF0;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ss", int'(ssn[0]), 1);
    chk("abort_sck", int'(sk[0]), 0);
    chk("abort_busy", int'(bsy[0]), 0);
    chk("abort_new_data", int'(nd[0]), 0);
    chk("abort_data_out", int'(dout[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    xfer(0, 8'h66, 2'd2, 1, -1, 72, 8'h66, 8'h66);
    xfer(1, 8'h81, 2'd2, 1, -1, 18, 8'h81, 8'h81);
    repeat (10) @(negedge clk);
    chk("new_data_level", int'(nd[1]), 1);
    din[1] = 8'h42;
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    chk("new_data_clear", int'(nd[1]), 0);
    chk("busy_after_accept", int'(bsy[1]), 1);
    n = 0;
    while (n < 40 && bsy[1]) begin
      @(negedge clk);
      n++;
    end
    chk("div1_done", int'(bsy[1]), 0);
    chk("div1_data_out", int'(dout[1]), 8'h42);
    xfer(0, 8'h01, 2'd2, 1, -1, 72, 8'h01, col01);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
